writeback: RTL and testbench

Writeback stage of the unpipelined 16-bit processor: the write-side counterpart of decode. Accepts one retiring instruction per handshake from execute/memory and selects the result (ALU, load data, or link PC). It waits a bounded number of cycles for variable-latency load data, then drives the register-file write port for exactly one cycle. It also exports the pending destination register so decode can stall on a read-after-write hazard, and it flags halt and error conditions.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_timeout_ctr.sv | 38 +++
 rtl/writeback.sv | 123 ++++++++++++
 tb/tb_writeback.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions: opcode, result-source encoding, link register, FSM state codes.
// Decode imports the same wb_src encoding so both stages agree on it.
package wb_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_NONE = 2'd3
    } wb_src_e;

    typedef logic [2:0] wb_state_t;

    localparam wb_state_t ST_IDLE     = 3'd0;
    localparam wb_state_t ST_WAIT_MEM = 3'd1;
    localparam wb_state_t ST_COMMIT   = 3'd2;
    localparam wb_state_t ST_HALTED   = 3'd3;
    localparam wb_state_t ST_ERROR    = 3'd4;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Load-response timeout counter: clear on load accept, count each waiting cycle, saturate.
// expired_o is decoded from the count and marks the last cycle a response may still arrive.
module wb_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] SAT   = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/writeback.sv
// Writeback stage: accepts one retiring instruction, selects ALU/load/link result and writes the RF for one cycle.
// ALU/LINK write the cycle after accept; loads wait up to MEM_TIMEOUT cycles; in_ready low while waiting or stopped.
module writeback
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [1:0]  in_wb_src,
    input  logic [2:0]  in_dest,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_pc_inc,
    input  logic        mem_rd_valid,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_err,
    output logic        rf_write,
    output logic [2:0]  rf_writeregsel,
    output logic [15:0] rf_writedata,
    output logic        pend_valid,
    output logic [2:0]  pend_reg,
    output logic        halt,
    output logic        err
);

    wb_state_t   state_q, state_d;
    logic [2:0]  dest_q, dest_d;
    logic [15:0] data_q, data_d;
    logic        accept;
    logic        ctr_clear, ctr_en, ctr_expired;

    assign in_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_COMMIT));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        data_d    = data_q;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                // Any memory response here was never requested.
                if (mem_rd_valid || mem_err) begin
                    state_d = ST_ERROR;
                end else if (accept) begin
                    if (in_opcode == OP_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        case (in_wb_src)
                            WB_ALU: begin
                                dest_d  = in_dest;
                                data_d  = in_alu;
                                state_d = ST_COMMIT;
                            end
                            WB_LINK: begin
                                dest_d  = LINK_REG;
                                data_d  = in_pc_inc;
                                state_d = ST_COMMIT;
                            end
                            WB_MEM: begin
                                dest_d    = in_dest;
                                ctr_clear = 1'b1;
                                state_d   = ST_WAIT_MEM;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_err) begin
                    state_d = ST_ERROR;
                end else if (mem_rd_valid) begin
                    data_d  = mem_rd_data;
                    state_d = ST_COMMIT;
                end else if (ctr_expired) begin
                    state_d = ST_ERROR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_HALTED, ST_ERROR: state_d = state_q;
            default:             state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    wb_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (ctr_clear),
        .enable_i  (ctr_en),
        .expired_o (ctr_expired)
    );

    assign rf_write       = (state_q == ST_COMMIT);
    assign rf_writeregsel = rf_write ? dest_q : 3'd0;
    assign rf_writedata   = rf_write ? data_q : 16'd0;
    assign pend_valid     = (state_q == ST_WAIT_MEM) || (state_q == ST_COMMIT);
    assign pend_reg       = pend_valid ? dest_q : 3'd0;
    assign halt           = (state_q == ST_HALTED);
    assign err            = (state_q == ST_ERROR);

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback; register-file writes are checked against a queue of expected writes.
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [1:0]  in_wb_src;
    logic [2:0]  in_dest;
    logic [15:0] in_alu;
    logic [15:0] in_pc_inc;
    logic        mem_rd_valid;
    logic [15:0] mem_rd_data;
    logic        mem_err;
    logic        rf_write;
    logic [2:0]  rf_writeregsel;
    logic [15:0] rf_writedata;
    logic        pend_valid;
    logic [2:0]  pend_reg;
    logic        halt;
    logic        err;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    writeback #(.MEM_TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_wb_src      (in_wb_src),
        .in_dest        (in_dest),
        .in_alu         (in_alu),
        .in_pc_inc      (in_pc_inc),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .mem_err        (mem_err),
        .rf_write       (rf_write),
        .rf_writeregsel (rf_writeregsel),
        .rf_writedata   (rf_writedata),
        .pend_valid     (pend_valid),
        .pend_reg       (pend_reg),
        .halt           (halt),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] src, input logic [2:0] dst,
                         input logic [15:0] alu, input logic [15:0] pci);
        in_valid  = 1'b1;
        in_opcode = op;
        in_wb_src = src;
        in_dest   = dst;
        in_alu    = alu;
        in_pc_inc = pci;
    endtask

    task automatic push(input logic [2:0] r, input logic [15:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Every observed register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rf_write) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(rf_write), 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_reg", 32'(rf_writeregsel), 32'(e.r));
                chk("wr_data", 32'(rf_writedata), 32'(e.d));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_opcode    = 5'h01;
        in_wb_src    = 2'd3;
        in_dest      = 3'd0;
        in_alu       = 16'h0;
        in_pc_inc    = 16'h0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'h0;
        mem_err      = 1'b0;

        // Reset state
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_rf_write", 32'(rf_write), 0);
        chk("rst_pend_valid", 32'(pend_valid), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        // ALU retire
        drive(5'h01, 2'd0, 3'd3, 16'h1234, 16'h0);
        push(3'd3, 16'h1234);
        step();
        in_valid = 1'b0;
        chk("alu_rf_write", 32'(rf_write), 1);
        chk("alu_pend_valid", 32'(pend_valid), 1);
        chk("alu_pend_reg", 32'(pend_reg), 3);
        step();
        chk("alu_done_rf_write", 32'(rf_write), 0);
        chk("alu_done_pend", 32'(pend_valid), 0);
        chk("alu_done_ready", 32'(in_ready), 1);

        // LINK retire ignores in_dest
        drive(5'h02, 2'd2, 3'd1, 16'hFFFF, 16'h0042);
        push(3'd7, 16'h0042);
        step();
        in_valid = 1'b0;
        chk("link_rf_write", 32'(rf_write), 1);
        chk("link_sel", 32'(rf_writeregsel), 7);
        step();

        // NONE retires without a write
        drive(5'h03, 2'd3, 3'd4, 16'h5555, 16'h0);
        step();
        in_valid = 1'b0;
        chk("none_rf_write", 32'(rf_write), 0);
        chk("none_pend", 32'(pend_valid), 0);
        chk("none_ready", 32'(in_ready), 1);

        // Load with latency 4
        drive(5'h04, 2'd1, 3'd6, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        chk("ld4_ready", 32'(in_ready), 0);
        chk("ld4_pend", 32'(pend_valid), 1);
        chk("ld4_pend_reg", 32'(pend_reg), 6);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("ld4_wait_ready", 32'(in_ready), 0);
            chk("ld4_wait_pend", 32'(pend_valid), 1);
            chk("ld4_wait_nowrite", 32'(rf_write), 0);
        end
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hBEEF;
        push(3'd6, 16'hBEEF);
        step();
        mem_rd_valid = 1'b0;
        chk("ld4_rf_write", 32'(rf_write), 1);
        chk("ld4_err", 32'(err), 0);
        step();
        chk("ld4_single_write", 32'(rf_write), 0);
        chk("ld4_err_after", 32'(err), 0);

        // Load answered on the last permitted cycle
        drive(5'h04, 2'd1, 3'd4, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 15; i++) begin
            step();
            chk("ld15_wait_err", 32'(err), 0);
            chk("ld15_wait_ready", 32'(in_ready), 0);
        end
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hA5A5;
        push(3'd4, 16'hA5A5);
        step();
        mem_rd_valid = 1'b0;
        chk("ld15_rf_write", 32'(rf_write), 1);
        chk("ld15_err", 32'(err), 0);
        step();

        // Back-to-back ALU retires
        drive(5'h05, 2'd0, 3'd2, 16'h0001, 16'h0);
        push(3'd2, 16'h0001);
        step();
        chk("b2b_first_write", 32'(rf_write), 1);
        chk("b2b_commit_ready", 32'(in_ready), 1);
        drive(5'h05, 2'd0, 3'd5, 16'h0002, 16'h0);
        push(3'd5, 16'h0002);
        step();
        in_valid = 1'b0;
        chk("b2b_second_write", 32'(rf_write), 1);
        chk("b2b_second_sel", 32'(rf_writeregsel), 5);
        step();
        chk("b2b_done", 32'(rf_write), 0);

        // HALT is sticky and blocks further retires
        drive(5'b00000, 2'd0, 3'd1, 16'h7777, 16'h0);
        step();
        chk("halt_set", 32'(halt), 1);
        chk("halt_ready", 32'(in_ready), 0);
        chk("halt_nowrite", 32'(rf_write), 0);
        drive(5'h01, 2'd0, 3'd1, 16'h7777, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_sticky", 32'(halt), 1);
            chk("halt_ignore_write", 32'(rf_write), 0);
            chk("halt_ignore_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;

        // Reset mid-load drops the load; a late response is unsolicited
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("post_halt_reset", 32'(halt), 0);
        drive(5'h04, 2'd1, 3'd3, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("midld_pend", 32'(pend_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midld_rst_outputs",
            32'({rf_write, rf_writeregsel, rf_writedata, pend_valid, pend_reg, halt, err, in_ready}), 0);
        step();
        rst_n = 1'b1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hDEAD;
        step();
        mem_rd_valid = 1'b0;
        chk("stray_err", 32'(err), 1);
        chk("stray_nowrite", 32'(rf_write), 0);
        chk("stray_ready", 32'(in_ready), 0);
        step();
        chk("stray_err_sticky", 32'(err), 1);

        // Load timeout with no response
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("to_reset_err", 32'(err), 0);
        drive(5'h04, 2'd1, 3'd2, 16'h0, 16'h0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 15; i++) begin
            step();
            chk("to_wait_err", 32'(err), 0);
        end
        step();
        chk("to_err", 32'(err), 1);
        chk("to_ready", 32'(in_ready), 0);
        chk("to_nowrite", 32'(rf_write), 0);
        step();
        chk("to_err_sticky", 32'(err), 1);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
